alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Two-requester round-robin arbiter and issue register in front of the shared combinational alu. Requester 0 is the execute stage and requester 1 is the address/branch-target unit. Each requester uses a valid/ready request channel and a valid/ready response channel. Responses come from the single alu instance and are returned to the granted requester one cycle after acceptance; per-port grant counters are kept for performance monitoring.

Parameters:
CNT_W, 16, width of per-port grant counters (saturating)

Ports:
sysclk  in  1  clock, rising edge
cpu_resetn  in  1  reset, asynchronous, active-low
flush  in  1  synchronous discard of in-flight op; blocks accepts this cycle
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted when valid&ready
req0_alucode  in  6  port 0 ALU_* code (define.vh)
req0_op1  in  32  port 0 operand 1
req0_op2  in  32  port 0 operand 2
req1_valid / req1_ready / req1_alucode / req1_op1 / req1_op2: same as port 0, for port 1
rsp0_valid  out  1  port 0 result valid
rsp0_ready  in  1  port 0 consumes result
rsp0_result  out  32  alu_result; 0 when rsp0_valid=0
rsp0_br_taken  out  1  br_taken; DISABLE when rsp0_valid=0
rsp1_valid / rsp1_ready / rsp1_result / rsp1_br_taken: same as port 0, for port 1
grant0_cnt  out  CNT_W  accepted requests on port 0
grant1_cnt  out  CNT_W  accepted requests on port 1

Behaviour:
- Reset (cpu_resetn=0, async):
  - issue_valid=0, issue_owner=0, issue_alucode=ALU_ADD, issue_op1=issue_op2=0.
  - rr_prio=0 (port 0 preferred); counters=0.
  - All rsp*_valid=0, rsp*_result=0, rsp*_br_taken=DISABLE, req*_ready=0.
- Issue register: a single entry holding alucode, op1, op2 and owner. The alu is driven only from the issue register, never from request ports.
- can_accept = !issue_valid | rspX_ready (X = issue_owner). Combinational from registered state plus rsp ready; allows back-to-back throughput of 1 op/cycle.
- Grant (combinational):
  - Only one port valid: that port wins.
  - Both valid: port rr_prio wins.
  - req_k_ready = can_accept & !flush & win_k. The loser's ready=0 and it must hold its request stable.
- On accept (valid&ready) at edge N:
  - Issue register loads the request; issue_valid=1; owner=k.
  - rr_prio <= 1-k.
  - grant_k_cnt++ (saturates at all-ones).
- Latency: rsp_k_valid=1 in cycle N+1 (registered-issue, combinational alu), with result/br_taken from the alu.
- Response hold: while rsp_k_valid & !rsp_k_ready, the issue register and outputs stay stable and no new accept occurs.
- Response consumed with no new accept: issue_valid <= 0.
- flush=1:
  - issue_valid <= 0 at the next edge (response dropped even if the ready is high that cycle).
  - No accept that cycle; rr_prio and counters unchanged.
- Reset mid-operation: the in-flight op is discarded, no response is produced, and counters are cleared.
- rr_prio changes only on accept; an idle cycle preserves it.
- alucode values are passed through unchecked; an unknown code yields whatever the alu returns (0, DISABLE).

Decomposition:
- define.vh (shared):
  - Existing ALU_* codes and ENABLE/DISABLE.
  - Add ARB_PORT0=1'b0 and ARB_PORT1=1'b1 for owner/priority encoding.
- Sub-module: the existing alu, instantiated once as the only datapath. The grant logic stays inline; no separate arbiter module.

Test Plan:
1. Port 0 only, ALU_ADD, 34+55 -> next cycle rsp0_valid=1, rsp0_result=89, rsp0_br_taken=DISABLE, grant0_cnt=1, rsp1_valid=0.
2. Both valid in the same cycle:
   - Port 0: ALU_SUB 55,56. Port 1: ALU_JAL op2=0x40000.
   - Port 0 wins first: rsp0_result=0xFFFFFFFF.
   - Port 1 is accepted the next cycle: rsp1_result=0x40004, br_taken=ENABLE.
   - rr_prio alternates on each accept.
3. Back-pressure: port 1 ALU_BEQ 0xBAADF00D,0xBAADF00D with rsp1_ready=0 for 3 cycles -> rsp1_valid/br_taken=ENABLE held stable, req0_ready=0 throughout; rsp1_ready=1 -> a queued port-0 ALU_XOR completes the next cycle with 0x443151D0.
4. Flush: port 0 ALU_SLL 0xFEEDFACE,12 accepted, flush=1 in the following cycle -> rsp0_valid never asserts with 0xDFACE000; the issue register is empty next cycle and grant0_cnt=1.
5. Reset mid-op: accept ALU_SRA 0xDEADDEAD,16, then assert cpu_resetn=0 between edges -> all rsp_valid=0 and counters=0 immediately; after release, ALU_LUI op2=5054464 returns 5054464.
6. Counter saturation: preload via CNT_W=2 build, 5 port-0 accepts -> grant0_cnt=3.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for the ALU arbiter slice: ALU opcodes, enable levels, port ids and the
// issue-register entry layout.
package alu_arbiter_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic ARB_PORT0 = 1'b0;
  localparam logic ARB_PORT1 = 1'b1;

  localparam logic [5:0] ALU_LUI  = 6'd1;
  localparam logic [5:0] ALU_JAL  = 6'd2;
  localparam logic [5:0] ALU_JALR = 6'd3;
  localparam logic [5:0] ALU_BEQ  = 6'd4;
  localparam logic [5:0] ALU_BNE  = 6'd5;
  localparam logic [5:0] ALU_BLT  = 6'd6;
  localparam logic [5:0] ALU_BGE  = 6'd7;
  localparam logic [5:0] ALU_BLTU = 6'd8;
  localparam logic [5:0] ALU_BGEU = 6'd9;
  localparam logic [5:0] ALU_ADD  = 6'd18;
  localparam logic [5:0] ALU_SUB  = 6'd19;
  localparam logic [5:0] ALU_SLT  = 6'd20;
  localparam logic [5:0] ALU_SLTU = 6'd21;
  localparam logic [5:0] ALU_XOR  = 6'd22;
  localparam logic [5:0] ALU_OR   = 6'd23;
  localparam logic [5:0] ALU_AND  = 6'd24;
  localparam logic [5:0] ALU_SLL  = 6'd25;
  localparam logic [5:0] ALU_SRL  = 6'd26;
  localparam logic [5:0] ALU_SRA  = 6'd27;

  typedef struct packed {
    logic [5:0]  alucode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        owner;
  } issue_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU; unknown codes produce a zero result with no branch.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [5:0]  alucode_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  output logic [31:0] result_o,
  output logic        br_taken_o
);

  logic [4:0] shamt;
  assign shamt = op2_i[4:0];

  always_comb begin
    result_o   = '0;
    br_taken_o = DISABLE;
    case (alucode_i)
      ALU_LUI:  result_o = op2_i;
      ALU_JAL, ALU_JALR: begin
        // Link address: the target operand plus one instruction.
        result_o   = op2_i + 32'd4;
        br_taken_o = ENABLE;
      end
      ALU_BEQ:  br_taken_o = (op1_i == op2_i);
      ALU_BNE:  br_taken_o = (op1_i != op2_i);
      ALU_BLT:  br_taken_o = ($signed(op1_i) < $signed(op2_i));
      ALU_BGE:  br_taken_o = ($signed(op1_i) >= $signed(op2_i));
      ALU_BLTU: br_taken_o = (op1_i < op2_i);
      ALU_BGEU: br_taken_o = (op1_i >= op2_i);
      ALU_ADD:  result_o = op1_i + op2_i;
      ALU_SUB:  result_o = op1_i - op2_i;
      ALU_SLT:  result_o = {31'b0, $signed(op1_i) < $signed(op2_i)};
      ALU_SLTU: result_o = {31'b0, op1_i < op2_i};
      ALU_XOR:  result_o = op1_i ^ op2_i;
      ALU_OR:   result_o = op1_i | op2_i;
      ALU_AND:  result_o = op1_i & op2_i;
      ALU_SLL:  result_o = op1_i << shamt;
      ALU_SRL:  result_o = op1_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(op1_i) >>> shamt);
      default: begin
        result_o   = '0;
        br_taken_o = DISABLE;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter feeding a single-entry issue register in front of the shared ALU.
// Results return to the owning port one cycle after acceptance.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             sysclk,
  input  logic             cpu_resetn,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_alucode,
  input  logic [31:0]      req0_op1,
  input  logic [31:0]      req0_op2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_alucode,
  input  logic [31:0]      req1_op1,
  input  logic [31:0]      req1_op2,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic             rsp0_br_taken,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic             rsp1_br_taken,
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt
);

  issue_t             issue_q, issue_d;
  logic               issue_valid_q, issue_valid_d;
  logic               rr_prio_q, rr_prio_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;

  logic        owner_ready;
  logic        can_accept;
  logic        win0, win1;
  logic        acc0, acc1;
  logic        owner_rsp_done;
  logic [31:0] alu_result;
  logic        alu_br_taken;

  alu_arbiter_alu u_alu (
    .alucode_i  (issue_q.alucode),
    .op1_i      (issue_q.op1),
    .op2_i      (issue_q.op2),
    .result_o   (alu_result),
    .br_taken_o (alu_br_taken)
  );

  // Grant and handshake
  always_comb begin
    owner_ready = (issue_q.owner == ARB_PORT1) ? rsp1_ready : rsp0_ready;
    can_accept  = !issue_valid_q || owner_ready;
    win0        = req0_valid && (!req1_valid || (rr_prio_q == ARB_PORT0));
    win1        = req1_valid && (!req0_valid || (rr_prio_q == ARB_PORT1));
    // Ready is held low while reset is asserted so no handshake is seen during reset.
    req0_ready  = cpu_resetn && can_accept && !flush && win0;
    req1_ready  = cpu_resetn && can_accept && !flush && win1;
    acc0        = req0_valid && req0_ready;
    acc1        = req1_valid && req1_ready;
    owner_rsp_done = issue_valid_q && owner_ready;
  end

  // Next state
  always_comb begin
    issue_d       = issue_q;
    issue_valid_d = issue_valid_q;
    rr_prio_d     = rr_prio_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    if (flush) begin
      issue_valid_d = 1'b0;
    end else if (acc0) begin
      issue_d       = '{alucode: req0_alucode, op1: req0_op1, op2: req0_op2, owner: ARB_PORT0};
      issue_valid_d = 1'b1;
      rr_prio_d     = ARB_PORT1;
      if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
    end else if (acc1) begin
      issue_d       = '{alucode: req1_alucode, op1: req1_op1, op2: req1_op2, owner: ARB_PORT1};
      issue_valid_d = 1'b1;
      rr_prio_d     = ARB_PORT0;
      if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
    end else if (owner_rsp_done) begin
      issue_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      issue_q       <= '{alucode: ALU_ADD, op1: '0, op2: '0, owner: ARB_PORT0};
      issue_valid_q <= 1'b0;
      rr_prio_q     <= ARB_PORT0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
    end else begin
      issue_q       <= issue_d;
      issue_valid_q <= issue_valid_d;
      rr_prio_q     <= rr_prio_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
    end
  end

  // Responses are masked during flush so a discarded op is never visible.
  always_comb begin
    rsp0_valid    = issue_valid_q && (issue_q.owner == ARB_PORT0) && !flush;
    rsp1_valid    = issue_valid_q && (issue_q.owner == ARB_PORT1) && !flush;
    rsp0_result   = rsp0_valid ? alu_result : '0;
    rsp1_result   = rsp1_valid ? alu_result : '0;
    rsp0_br_taken = rsp0_valid ? alu_br_taken : DISABLE;
    rsp1_br_taken = rsp1_valid ? alu_br_taken : DISABLE;
    grant0_cnt    = cnt0_q;
    grant1_cnt    = cnt1_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arbitration, latency, back-pressure, flush, reset and
// counter saturation (second instance with 2-bit counters).
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        sysclk = 1'b0;
  logic        cpu_resetn;
  logic        flush;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_alucode, req1_alucode;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic        rsp0_valid, rsp0_ready, rsp0_br_taken;
  logic        rsp1_valid, rsp1_ready, rsp1_br_taken;
  logic [31:0] rsp0_result, rsp1_result;
  logic [15:0] grant0_cnt, grant1_cnt;

  logic        s_req0_valid, s_req0_ready, s_req1_ready;
  logic        s_rsp0_valid, s_rsp0_br_taken, s_rsp1_valid, s_rsp1_br_taken;
  logic [31:0] s_rsp0_result, s_rsp1_result;
  logic [1:0]  s_grant0_cnt, s_grant1_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sysclk = ~sysclk;

  alu_arbiter #(.CNT_W(16)) u_dut (
    .sysclk        (sysclk),
    .cpu_resetn    (cpu_resetn),
    .flush         (flush),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_alucode  (req0_alucode),
    .req0_op1      (req0_op1),
    .req0_op2      (req0_op2),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_alucode  (req1_alucode),
    .req1_op1      (req1_op1),
    .req1_op2      (req1_op2),
    .rsp0_valid    (rsp0_valid),
    .rsp0_ready    (rsp0_ready),
    .rsp0_result   (rsp0_result),
    .rsp0_br_taken (rsp0_br_taken),
    .rsp1_valid    (rsp1_valid),
    .rsp1_ready    (rsp1_ready),
    .rsp1_result   (rsp1_result),
    .rsp1_br_taken (rsp1_br_taken),
    .grant0_cnt    (grant0_cnt),
    .grant1_cnt    (grant1_cnt)
  );

  alu_arbiter #(.CNT_W(2)) u_dut_sat (
    .sysclk        (sysclk),
    .cpu_resetn    (cpu_resetn),
    .flush         (1'b0),
    .req0_valid    (s_req0_valid),
    .req0_ready    (s_req0_ready),
    .req0_alucode  (ALU_ADD),
    .req0_op1      (32'd1),
    .req0_op2      (32'd1),
    .req1_valid    (1'b0),
    .req1_ready    (s_req1_ready),
    .req1_alucode  (ALU_ADD),
    .req1_op1      (32'd0),
    .req1_op2      (32'd0),
    .rsp0_valid    (s_rsp0_valid),
    .rsp0_ready    (1'b1),
    .rsp0_result   (s_rsp0_result),
    .rsp0_br_taken (s_rsp0_br_taken),
    .rsp1_valid    (s_rsp1_valid),
    .rsp1_ready    (1'b1),
    .rsp1_result   (s_rsp1_result),
    .rsp1_br_taken (s_rsp1_br_taken),
    .grant0_cnt    (s_grant0_cnt),
    .grant1_cnt    (s_grant1_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [5:0] c, input logic [31:0] a,
                        input logic [31:0] b);
    req0_valid = v; req0_alucode = c; req0_op1 = a; req0_op2 = b;
  endtask

  task automatic drive1(input logic v, input logic [5:0] c, input logic [31:0] a,
                        input logic [31:0] b);
    req1_valid = v; req1_alucode = c; req1_op1 = a; req1_op2 = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    cpu_resetn = 1'b0;
    flush      = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    s_req0_valid = 1'b0;
    drive0(1'b1, ALU_ADD, 32'd1, 32'd2);
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
    #1;
    check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    check("rst_rsp0_result", rsp0_result, 32'd0);
    check("rst_rsp0_br", {31'b0, rsp0_br_taken}, 32'd0);
    check("rst_grant0", {16'b0, grant0_cnt}, 32'd0);
    check("rst_grant1", {16'b0, grant1_cnt}, 32'd0);
    repeat (2) @(posedge sysclk);
    #3;
    cpu_resetn = 1'b1;

    // Port 0 only: ADD 34+55
    drive0(1'b1, ALU_ADD, 32'd34, 32'd55);
    #1;
    check("t1_req0_ready", {31'b0, req0_ready}, 32'd1);
    tick();
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    #1;
    check("t1_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    check("t1_rsp0_result", rsp0_result, 32'd89);
    check("t1_rsp0_br", {31'b0, rsp0_br_taken}, 32'd0);
    check("t1_grant0", {16'b0, grant0_cnt}, 32'd1);
    check("t1_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    tick();
    check("t1_drain", {31'b0, rsp0_valid}, 32'd0);

    // Port 1 only: ADD 7+8, hands priority back to port 0
    drive1(1'b1, ALU_ADD, 32'd7, 32'd8);
    #1;
    check("p1_req1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
    #1;
    check("p1_rsp1_result", rsp1_result, 32'd15);
    check("p1_grant1", {16'b0, grant1_cnt}, 32'd1);

    // Both valid: port 0 wins, port 1 follows back-to-back
    drive0(1'b1, ALU_SUB, 32'd55, 32'd56);
    drive1(1'b1, ALU_JAL, 32'd0, 32'h0004_0000);
    #1;
    check("t2_req0_ready", {31'b0, req0_ready}, 32'd1);
    check("t2_req1_ready", {31'b0, req1_ready}, 32'd0);
    tick();
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    #1;
    check("t2_rsp0_result", rsp0_result, 32'hFFFF_FFFF);
    check("t2_req1_ready2", {31'b0, req1_ready}, 32'd1);
    tick();
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
    #1;
    check("t2_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
    check("t2_rsp1_result", rsp1_result, 32'h0004_0004);
    check("t2_rsp1_br", {31'b0, rsp1_br_taken}, 32'd1);
    check("t2_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    check("t2_grant0", {16'b0, grant0_cnt}, 32'd2);
    check("t2_grant1", {16'b0, grant1_cnt}, 32'd2);
    tick();

    // Back-pressure on port 1 with a queued port-0 request
    rsp1_ready = 1'b0;
    drive1(1'b1, ALU_BEQ, 32'hBAAD_F00D, 32'hBAAD_F00D);
    #1;
    tick();
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
    drive0(1'b1, ALU_XOR, 32'hDEAD_BEEF, 32'h9A9C_EF3F);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_valid", {31'b0, rsp1_valid}, 32'd1);
      check("t3_hold_br", {31'b0, rsp1_br_taken}, 32'd1);
      check("t3_req0_blocked", {31'b0, req0_ready}, 32'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    check("t3_req0_ready", {31'b0, req0_ready}, 32'd1);
    tick();
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    #1;
    check("t3_rsp0_result", rsp0_result, 32'h4431_51D0);
    check("t3_rsp1_done", {31'b0, rsp1_valid}, 32'd0);
    check("t3_grant0", {16'b0, grant0_cnt}, 32'd3);
    check("t3_grant1", {16'b0, grant1_cnt}, 32'd3);
    tick();

    // Flush drops the in-flight SLL
    drive0(1'b1, ALU_SLL, 32'hFEED_FACE, 32'd12);
    #1;
    tick();
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    flush = 1'b1;
    #1;
    check("t4_flush_valid", {31'b0, rsp0_valid}, 32'd0);
    check("t4_flush_result", rsp0_result, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("t4_empty", {31'b0, rsp0_valid}, 32'd0);
    check("t4_grant0", {16'b0, grant0_cnt}, 32'd4);
    // Flush blocks accepts and leaves priority (now port 1) untouched
    drive0(1'b1, ALU_ADD, 32'd1, 32'd1);
    drive1(1'b1, ALU_ADD, 32'd2, 32'd2);
    flush = 1'b1;
    #1;
    check("t4_blk_req0", {31'b0, req0_ready}, 32'd0);
    check("t4_blk_req1", {31'b0, req1_ready}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("t4_prio_req1", {31'b0, req1_ready}, 32'd1);
    check("t4_prio_req0", {31'b0, req0_ready}, 32'd0);
    check("t4_grant1", {16'b0, grant1_cnt}, 32'd3);
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0);

    // Reset mid-operation
    drive0(1'b1, ALU_SRA, 32'hDEAD_DEAD, 32'd16);
    #1;
    tick();
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    #1;
    check("t5_sra", rsp0_result, 32'hFFFF_DEAD);
    #2;
    cpu_resetn = 1'b0;
    #1;
    check("t5_rst_rsp0", {31'b0, rsp0_valid}, 32'd0);
    check("t5_rst_rsp1", {31'b0, rsp1_valid}, 32'd0);
    check("t5_rst_grant0", {16'b0, grant0_cnt}, 32'd0);
    check("t5_rst_grant1", {16'b0, grant1_cnt}, 32'd0);
    #3;
    cpu_resetn = 1'b1;
    tick();
    check("t5_no_rsp", {31'b0, rsp0_valid}, 32'd0);
    drive0(1'b1, ALU_LUI, 32'd0, 32'd5054464);
    #1;
    tick();
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    #1;
    check("t5_lui", rsp0_result, 32'd5054464);
    check("t5_grant0", {16'b0, grant0_cnt}, 32'd1);
    tick();

    // Unknown code passes through: zero result, no branch
    drive0(1'b1, 6'h3F, 32'd1, 32'd2);
    #1;
    tick();
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    #1;
    check("unk_valid", {31'b0, rsp0_valid}, 32'd1);
    check("unk_result", rsp0_result, 32'd0);
    check("unk_br", {31'b0, rsp0_br_taken}, 32'd0);
    tick();

    // Saturation on the 2-bit counter instance
    s_req0_valid = 1'b1;
    #1;
    repeat (2) tick();
    check("t6_cnt2", {30'b0, s_grant0_cnt}, 32'd2);
    repeat (3) tick();
    check("t6_sat", {30'b0, s_grant0_cnt}, 32'd3);
    check("t6_rsp", s_rsp0_result, 32'd2);
    s_req0_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
